// File: rtl/rssb_exec.sv
// -----------------------------------------------------------------------------
// rssb_exec
// Execute/sequencing stage of the RSSB (reverse-subtract-and-skip-if-borrow)
// one-instruction processor. It owns the program counter and the accumulator.
//
// Every instruction takes exactly three cycles:
//   FETCH  - present pc to the synchronous program ROM
//   DECODE - latch the operand address; either halt or start the data read
//   EXEC   - compute mem - acc, write it back to data memory and to acc,
//            then advance pc by 1, or by 2 on borrow
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   start           begin execution from pc=0 (only looked at in IDLE)
//   rom_addr/data   program ROM address (always pc) and its registered word
//   ram_addr/re     data-memory address and read strobe (data next cycle)
//   ram_rdata       data-memory read data
//   ram_we/wdata    data-memory write enable and write data
//   pc, acc, borrow architectural state
//   instr_done      one-cycle pulse per retired instruction
//   halted          high while in HALT
// -----------------------------------------------------------------------------
module rssb_exec #(
    parameter int                WIDTH     = 8,
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] HALT_ADDR = {ADDR_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [ADDR_W-1:0] rom_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_re,
    input  logic [WIDTH-1:0]  ram_rdata,
    output logic              ram_we,
    output logic [WIDTH-1:0]  ram_wdata,
    output logic [ADDR_W-1:0] pc,
    output logic [WIDTH-1:0]  acc,
    output logic              borrow,
    output logic              instr_done,
    output logic              halted
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    state_t             state_reg, state_next;
    logic [ADDR_W-1:0]  pc_reg, pc_next;
    logic [WIDTH-1:0]   acc_reg, acc_next;
    logic               borrow_reg, borrow_next;
    logic [ADDR_W-1:0]  ir_reg, ir_next;
    // Last driven memory address / write data, so both hold between strobes.
    logic [ADDR_W-1:0]  ram_addr_reg;
    logic [WIDTH-1:0]   ram_wdata_reg;

    logic [WIDTH-1:0]   diff;
    logic               sub_borrow;

    // Reverse subtract: memory minus accumulator, borrow is the unsigned compare.
    assign diff       = ram_rdata - acc_reg;
    assign sub_borrow = (ram_rdata < acc_reg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            pc_reg        <= '0;
            acc_reg       <= '0;
            borrow_reg    <= 1'b0;
            ir_reg        <= '0;
            ram_addr_reg  <= '0;
            ram_wdata_reg <= '0;
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            acc_reg       <= acc_next;
            borrow_reg    <= borrow_next;
            ir_reg        <= ir_next;
            ram_addr_reg  <= ram_addr;
            ram_wdata_reg <= ram_wdata;
        end
    end

    always_comb begin
        state_next  = state_reg;
        pc_next     = pc_reg;
        acc_next    = acc_reg;
        borrow_next = borrow_reg;
        ir_next     = ir_reg;
        ram_addr    = ram_addr_reg;
        ram_wdata   = ram_wdata_reg;
        ram_re      = 1'b0;
        ram_we      = 1'b0;
        instr_done  = 1'b0;
        halted      = 1'b0;

        unique case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // rom_addr is pc at all times; this cycle only waits for ROM.
                state_next = ST_DECODE;
            end
            ST_DECODE: begin
                ir_next = rom_data;
                if (rom_data == HALT_ADDR) begin
                    state_next = ST_HALT;
                end else begin
                    // Address comes straight from the ROM word so the data
                    // read completes in time for EXEC.
                    ram_addr   = rom_data;
                    ram_re     = 1'b1;
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                ram_addr    = ir_reg;
                ram_wdata   = diff;
                ram_we      = 1'b1;
                instr_done  = 1'b1;
                acc_next    = diff;
                borrow_next = sub_borrow;
                // Skip the next instruction on borrow; wraps modulo 2^ADDR_W.
                pc_next     = pc_reg + {{(ADDR_W-1){1'b0}}, 1'b1}
                                     + {{(ADDR_W-1){1'b0}}, sub_borrow};
                state_next  = ST_FETCH;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign rom_addr = pc_reg;
    assign pc       = pc_reg;
    assign acc      = acc_reg;
    assign borrow   = borrow_reg;

endmodule

// File: tb/tb_rssb_exec.sv
module tb_rssb_exec;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] rom_addr;
    logic [7:0] rom_data;
    logic [7:0] ram_addr;
    logic       ram_re;
    logic [7:0] ram_rdata;
    logic       ram_we;
    logic [7:0] ram_wdata;
    logic [7:0] pc;
    logic [7:0] acc;
    logic       borrow;
    logic       instr_done;
    logic       halted;

    int checks = 0;
    int errors = 0;

    logic [7:0] rom [256];
    logic [7:0] ram [256];
    logic       saw_rom2;

    rssb_exec dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .ram_addr   (ram_addr),
        .ram_re     (ram_re),
        .ram_rdata  (ram_rdata),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .pc         (pc),
        .acc        (acc),
        .borrow     (borrow),
        .instr_done (instr_done),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    // Synchronous program ROM and data RAM models.
    always @(posedge clk) begin
        rom_data <= rom[rom_addr];
        if (ram_re) ram_rdata <= ram[ram_addr];
        if (ram_we) ram[ram_addr] <= ram_wdata;
    end

    always @(negedge clk) begin
        if (rom_addr == 8'h02) saw_rom2 = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin
            rom[i] = 8'h00;
            ram[i] = 8'h00;
        end
    endtask

    // Entered #1 after the edge into FETCH; leaves #1 after the next FETCH edge.
    task automatic run_instr(input string tag, input logic [7:0] addr, input logic [7:0] wdata,
                             input logic [7:0] npc, input logic b);
        check({tag, "_rom_addr"}, rom_addr, pc);
        tick();
        check({tag, "_dec_re"}, ram_re, 1'b1);
        check({tag, "_dec_addr"}, ram_addr, addr);
        tick();
        check({tag, "_ex_we_re_done"}, {ram_we, ram_re, instr_done}, 3'b101);
        check({tag, "_ex_addr"}, ram_addr, addr);
        check({tag, "_ex_wdata"}, ram_wdata, wdata);
        tick();
        check({tag, "_pc"}, pc, npc);
        check({tag, "_acc"}, acc, wdata);
        check({tag, "_borrow"}, borrow, b);
        check({tag, "_ram"}, ram[addr], wdata);
        $display("instr %s: addr=%0h wdata=%0h pc=%0h borrow=%0b", tag, ram_addr, ram_wdata, pc, borrow);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        saw_rom2 = 1'b0;
        clear_mem();
        rom[0] = 8'h05; ram[5] = 8'h07;
        tick();
        check("rst_pc", pc, 8'h00);
        check("rst_acc", acc, 8'h00);
        check("rst_strobes", {ram_we, ram_re, instr_done, halted, borrow}, 5'b0);
        check("rst_ram_addr_wdata", {ram_addr, ram_wdata}, 16'h0000);
        rst = 1'b0;
        tick();

        // Abort mid-EXEC with an asynchronous reset.
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        check("abort_pre_we", ram_we, 1'b1);
        rst = 1'b1;
        #1;
        check("abort_we_drop", ram_we, 1'b0);
        check("abort_pc_acc", {pc, acc}, 16'h0000);
        tick();
        check("abort_no_write", ram[5], 8'h07);
        rst = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            check("idle_quiet", {ram_we, ram_re, instr_done, halted, pc}, 12'h000);
            tick();
        end
        $display("reset/idle phase done");

        // Main program: no borrow, borrow skip, equal operands, plain, halt.
        rom[1] = 8'h06; ram[6] = 8'h03;
        rom[2] = 8'hFF;
        rom[3] = 8'h07; ram[7] = 8'hFC;
        rom[4] = 8'h08; ram[8] = 8'h10;
        rom[5] = 8'hFF;
        saw_rom2 = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        run_instr("nobrw", 8'h05, 8'h07, 8'h01, 1'b0);
        run_instr("skip", 8'h06, 8'hFC, 8'h03, 1'b1);
        check("rom2_not_fetched", saw_rom2, 1'b0);
        run_instr("equal", 8'h07, 8'h00, 8'h04, 1'b0);
        run_instr("plain", 8'h08, 8'h10, 8'h05, 1'b0);

        // Halt at pc=5.
        tick();
        check("halt_decode", {halted, ram_re, ram_we}, 3'b000);
        tick();
        check("halt_on", halted, 1'b1);
        for (int i = 0; i < 4; i++) begin
            start = i[0];
            tick();
            check("halt_frozen", {halted, ram_re, ram_we, instr_done, pc, acc}, {4'b1000, 8'h05, 8'h10});
        end
        start = 1'b0;
        $display("halt phase: pc=%0h acc=%0h halted=%0b", pc, acc, halted);
        rst = 1'b1;
        #1;
        check("halt_rst", {halted, pc, acc}, 17'h0);
        tick();
        rst = 1'b0;
        tick();

        // PC wrap with borrow: 0xFE + 2 -> 0x00.
        clear_mem();
        for (int i = 0; i < 253; i++) rom[i] = 8'h10;
        rom[253] = 8'h21; ram[8'h21] = 8'h05;
        rom[254] = 8'h20; ram[8'h20] = 8'h02;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 3 * 253; i++) tick();
        check("walk_pc_fd", pc, 8'hFD);
        run_instr("to_fe", 8'h21, 8'h05, 8'hFE, 1'b0);
        run_instr("wrap_brw", 8'h20, 8'hFD, 8'h00, 1'b1);
        do_reset();

        // PC wrap without borrow: 0xFF + 1 -> 0x00.
        clear_mem();
        for (int i = 0; i < 255; i++) rom[i] = 8'h10;
        rom[255] = 8'h22; ram[8'h22] = 8'h09;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 3 * 255; i++) tick();
        check("walk_pc_ff", pc, 8'hFF);
        run_instr("wrap_nobrw", 8'h22, 8'h09, 8'h00, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rssb_exec.md
Name: rssb_exec

Overview:
- Execute/sequencing stage of the RSSB (reverse-subtract-and-skip-if-borrow) one-instruction processor.
- Owns the program counter and the accumulator.
- Fetches each operand address from program ROM, reads the data word, computes mem − acc, writes the result back to data memory and into acc, then advances the PC by 1, or by 2 on borrow.
- Sits directly upstream of the data-memory stage and drives its address, write-data and write-enable.

Parameters:
- WIDTH, 8, data word and accumulator width.
- ADDR_W, 8, PC / ROM address and data-RAM address width.
- HALT_ADDR, {ADDR_W{1'b1}}, operand value that halts execution (no memory access performed).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin execution from PC=0; sampled only in IDLE.
- rom_addr  out  ADDR_W  program ROM address (= pc).
- rom_data  in  ADDR_W  ROM word; synchronous ROM, valid one cycle after rom_addr.
- ram_addr  out  ADDR_W  data-memory address.
- ram_re  out  1  data-memory read strobe; read data valid the next cycle.
- ram_rdata  in  WIDTH  data-memory read data.
- ram_we  out  1  data-memory write enable.
- ram_wdata  out  WIDTH  data-memory write data.
- pc  out  ADDR_W  current program counter.
- acc  out  WIDTH  accumulator.
- borrow  out  1  borrow flag of the last executed instruction.
- instr_done  out  1  one-cycle pulse per retired instruction.
- halted  out  1  high while in HALT.

Behaviour:
- Reset (async, immediate):
  - pc=0, acc=0, borrow=0, ir=0, state=IDLE.
  - ram_we=0, ram_re=0, instr_done=0, halted=0, ram_addr=0, ram_wdata=0.
  - Assertion mid-instruction aborts it; no partial write may occur after rst rises.
- rom_addr is always equal to pc.
- States: IDLE, FETCH, DECODE, EXEC, HALT.
- IDLE:
  - All strobes low.
  - start=1 → FETCH; otherwise stay.
- FETCH: drive rom_addr=pc; → DECODE.
- DECODE:
  - Latch ir <= rom_data.
  - If rom_data==HALT_ADDR → HALT; ram_re stays 0.
  - Otherwise drive ram_addr=rom_data (combinational from rom_data) and ram_re=1 → EXEC.
- EXEC (ram_rdata valid):
  - diff = ram_rdata − acc, modulo 2^WIDTH.
  - b = (ram_rdata < acc), unsigned.
  - Same cycle: ram_addr=ir, ram_we=1, ram_wdata=diff, instr_done=1.
  - Registered: acc<=diff, borrow<=b, pc<=pc+1+b (mod 2^ADDR_W) → FETCH.
- HALT:
  - halted=1; pc, acc and borrow frozen.
  - All strobes low; start ignored; exit only via rst.
- Throughput: exactly 3 cycles per instruction (FETCH, DECODE, EXEC); no stalls.
- ram_re and ram_we are never high in the same cycle.
- ram_addr holds its last value when no strobe is active.
- PC wrap: 0xFF+1 → 0x00; 0xFE+2 → 0x00; 0xFF+2 → 0x01 (ADDR_W=8).
- ram_rdata == acc: diff=0, b=0, pc+1.
- Self-referencing operand: if ir equals an address currently written, that is the normal read-then-write of the same location; no special case.
- start held high continuously has no effect outside IDLE.

Test Plan:
- Reset/idle:
  - Assert rst mid-EXEC (ram_we=1) → ram_we drops in the same cycle; pc=0, acc=0, state IDLE.
  - Release, with start=0 for 10 cycles → no strobes, pc stays 0.
- No borrow: ROM[0]=0x05, RAM[5]=0x07, acc=0, pulse start.
  - Cycle 3: ram_we=1, ram_addr=5, ram_wdata=0x07, instr_done=1.
  - Afterwards acc=0x07, borrow=0, pc=1.
- Borrow skip: continue with ROM[1]=0x06, RAM[6]=0x03, acc=0x07.
  - ram_wdata=0xFC, acc=0xFC, borrow=1, pc=3.
  - ROM[2] is never fetched.
- Equal operands: acc=0x07, RAM[x]=0x07 → ram_wdata=0x00, borrow=0, pc increments by 1.
- PC wrap:
  - Preload a program that reaches pc=0xFE with a borrowing instruction → next pc=0x00.
  - pc=0xFF without borrow → 0x00.
- Halt:
  - ROM[k]=0xFF → halted=1 two cycles after FETCH of k; no ram_re/ram_we.
  - pc=k and acc unchanged; start pulses ignored; rst returns to IDLE with halted=0.
